seq_divider: RTL and testbench
==============================

# seq_divider

Sequential unsigned restoring divider. It computes `dividend / divisor` one quotient bit per clock, using the existing ripple-carry `addern` as its trial subtractor. It is the inverse companion to the combinational array multiplier built from `multi_and` and `addern`, and it sits beside that multiplier in the arithmetic datapath. A start/ready/done handshake lets a controller issue one division at a time and read a held result.

## Interface

Parameters:
- `n`, default 8: operand and result width in bits; legal for n ≥ 2.

Ports:
- `clk`  in  1: rising-edge clock; the block's only clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a division; sampled only while `ready`=1.
- `dividend`  in  n: unsigned dividend; sampled on the accepted `start`.
- `divisor`  in  n: unsigned divisor; sampled on the accepted `start`.
- `ready`  out  1: high in IDLE only; the block can accept `start`.
- `done`  out  1: single-cycle pulse; `quotient` and `remainder` are valid.
- `quotient`  out  n: unsigned quotient; held until the next accepted `start`.
- `remainder`  out  n: unsigned remainder; held until the next accepted `start`.
- `div_by_zero`  out  1: set with `done` when the divisor was 0; held until the next accepted `start`.

## Operation

- **States:** IDLE, RUN, DONE.
- **Reset values:**
  - State returns to IDLE.
  - `quotient`=0, `remainder`=0, `done`=0, `div_by_zero`=0.
  - Iteration counter = 0.
  - `ready`=1 from the first cycle after reset.
- **Reset priority:** `reset` overrides everything, including `start` in the same cycle and a division in progress. A division cut off by reset is abandoned; no `done` is produced.
- **IDLE, `start`=1:**
  - Latch both operands.
  - Set partial remainder R (n+1 bits) to 0, Q to `dividend`, counter to n.
  - Clear `div_by_zero`.
  - If `divisor`=0, go to DONE. Otherwise go to RUN.
- **RUN, once per cycle:**
  - Shift {R,Q} left by 1.
  - Compute trial T = R_shifted − {0,divisor} with an (n+1)-bit `addern`: carryin=1, Y=~{0,divisor}.
  - If carryout=1 (no borrow), set R=T and Q[0]=1. Otherwise keep R_shifted and set Q[0]=0.
  - Decrement the counter. Go to DONE after the iteration in which the counter reaches 0.
- **DONE:**
  - `done`=1 for this cycle only.
  - `quotient`=Q, `remainder`=R[n-1:0].
  - Go to IDLE on the next cycle.
- **Divide by zero:** `quotient`=all ones, `remainder`=`dividend`, `div_by_zero`=1.
- **`start` outside IDLE:** ignored. Operands are not re-sampled and the result is unaffected.
- **Width rule:** the result always satisfies `quotient`·`divisor` + `remainder` = `dividend` and `remainder` < `divisor`. R[n] is 0 at the end of every iteration.

## Timing

- Cycle 0: `start`=1 and `ready`=1 are sampled at the rising edge that ends cycle 0.
- Normal divide:
  - Cycles 1..n: RUN, `ready`=0.
  - Cycle n+1: DONE, `done`=1.
  - Cycle n+2: IDLE, `ready`=1.
  - Latency is n+1 cycles from accept to `done`; throughput is one division per n+2 cycles.
- Zero divisor: DONE in cycle 1, IDLE in cycle 2.
- The earliest next `start` is accepted in the first IDLE cycle after DONE. Back-to-back divisions have no extra bubble.
- `quotient`, `remainder` and `div_by_zero` change only on the edge entering DONE, and on reset. They are registered and stable for the whole `done` cycle.

## Structure

- Shared header/package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter-width macro: clog2(n+1).
- Sub-module: reuse `addern` with parameter n+1 as the trial subtractor. No other sub-modules.
- The FSM, the {R,Q} shift register and the counter live in `seq_divider`.

## Test plan

- **100 / 7, n=8:** start at cycle 0 → `done` at cycle 9 with `quotient`=14, `remainder`=2, `div_by_zero`=0; `ready`=1 at cycle 10.
- **Edge values, n=8:** 255/1 → 255 r 0; 5/9 → 0 r 5; 0/3 → 0 r 0. Each completes at cycle 9.
- **42 / 0:** `done` at cycle 1 with `quotient`=255, `remainder`=42, `div_by_zero`=1. The next division, 10/3, clears `div_by_zero` and gives 3 r 1.
- **`start` while busy:** start 200/10, then pulse `start` with 9/3 at cycle 4 → result is 20 r 0 at cycle 9; no second `done`.
- **Reset at cycle 5 of a run:** all outputs 0 and `ready`=1 from the cycle after reset; no `done` ever. A new 50/7 then yields 7 r 1.
- **n=16:** 65535/255 → 257 r 0 at cycle 17. Back-to-back 1000/33 started in the first IDLE cycle → 30 r 10.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//
// Shared definitions for the sequential restoring divider:
//   - state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - cnt_width : width of the iteration counter for a given operand width,
//                 i.e. clog2(width+1) so the counter can hold the value width.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : seq_divider_pkg

// File: rtl/addern.sv
// -----------------------------------------------------------------------------
// addern
//
// Parameterised ripple-carry adder: s = x + y + carryin.
// Used by seq_divider as a trial subtractor (y = ~b, carryin = 1 gives x - b,
// with carryout = 1 meaning "no borrow").
//
// Ports:
//   x, y      in  n : addends
//   carryin   in  1 : carry into bit 0
//   s         out n : sum
//   carryout  out 1 : carry out of bit n-1
// -----------------------------------------------------------------------------
module addern #(
    parameter int n = 8
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         carryin,
    output logic [n-1:0] s,
    output logic         carryout
);

    always_comb begin
        logic [n:0] carry;
        carry    = '0;
        s        = '0;
        carry[0] = carryin;
        for (int i = 0; i < n; i++) begin
            s[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
        end
        carryout = carry[n];
    end

endmodule : addern

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential unsigned restoring divider producing one quotient bit per clock.
// A start/ready/done handshake accepts one division at a time; the result is
// registered and held until the next accepted start.
//
// Parameters:
//   n            : operand / result width (n >= 2)
//
// Ports:
//   clk          in  1 : rising-edge clock
//   reset        in  1 : synchronous active-high reset
//   start        in  1 : request a division (honoured only while ready = 1)
//   dividend     in  n : unsigned dividend, sampled on the accepted start
//   divisor      in  n : unsigned divisor, sampled on the accepted start
//   ready        out 1 : high in IDLE; a start will be accepted
//   done         out 1 : one-cycle pulse, result outputs are valid
//   quotient     out n : unsigned quotient (all ones on divide by zero)
//   remainder    out n : unsigned remainder (dividend on divide by zero)
//   div_by_zero  out 1 : the last accepted divisor was zero
//
// Latency: n+1 cycles from accept to done (1 cycle for a zero divisor),
// with ready back high the cycle after done.
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(n);

    // Control state (reset)
    state_t          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            ready_q,  ready_d;
    logic            done_q,   done_d;
    logic            dz_q,     dz_d;
    logic [n-1:0]    quot_q,   quot_d;
    logic [n-1:0]    rem_q,    rem_d;

    // Datapath state (no reset needed; always loaded on accept)
    // The partial remainder is conceptually n+1 bits, but its top bit is zero
    // at the end of every iteration, so only the low n bits are stored.
    logic [n-1:0]    r_q,      r_d;
    logic [n-1:0]    q_q,      q_d;
    logic [n-1:0]    dvs_q,    dvs_d;

    // Trial subtraction
    logic [n:0]      r_shift;
    logic [n-1:0]    q_shift;
    logic [n:0]      trial;
    logic            no_borrow;
    logic            unused_trial_msb;

    // {R,Q} shifted left by one; the dividend bit leaving Q enters R.
    assign r_shift = {r_q, q_q[n-1]};
    assign q_shift = {q_q[n-2:0], 1'b0};

    // r_shift - {0,divisor} as r_shift + ~{0,divisor} + 1.
    addern #(
        .n (n + 1)
    ) u_trial_sub (
        .x        (r_shift),
        .y        (~{1'b0, dvs_q}),
        .carryin  (1'b1),
        .s        (trial),
        .carryout (no_borrow)
    );

    // A successful trial is always below the divisor, so its top bit is zero.
    assign unused_trial_msb = trial[n];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    r_d   = '0;
                    q_d   = dividend;
                    cnt_d = CW'(n);
                    dz_d  = 1'b0;
                    if (divisor == '0) begin
                        // Skip iteration entirely and publish the
                        // divide-by-zero result on the edge entering DONE.
                        state_d = DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (no_borrow) begin
                    r_d = trial[n-1:0];
                    q_d = {q_shift[n-1:1], 1'b1};
                end else begin
                    r_d = r_shift[n-1:0];
                    q_d = q_shift;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = q_d;
                    rem_d   = r_d;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Shift register and latched divisor
    always_ff @(posedge clk) begin
        r_q   <= r_d;
        q_q   <= q_d;
        dvs_q <= dvs_d;
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed and random checks of seq_divider at n=8 and n=16 against a
// plain-arithmetic reference (a/b, a%b, with the divide-by-zero convention).
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        start8;
    logic [7:0]  dvd8, dvs8;
    logic        ready8, done8, dz8;
    logic [7:0]  q8, r8;

    logic        start16;
    logic [15:0] dvd16, dvs16;
    logic        ready16, done16, dz16;
    logic [15:0] q16, r16;

    int n_assert = 0;
    int n_fail   = 0;

    seq_divider #(.n(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .start       (start8),
        .dividend    (dvd8),
        .divisor     (dvs8),
        .ready       (ready8),
        .done        (done8),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (dz8)
    );

    seq_divider #(.n(16)) dut16 (
        .clk         (clk),
        .reset       (reset),
        .start       (start16),
        .dividend    (dvd16),
        .divisor     (dvs16),
        .ready       (ready16),
        .done        (done16),
        .quotient    (q16),
        .remainder   (r16),
        .div_by_zero (dz16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic o_ready(input bit wide);
        return wide ? ready16 : ready8;
    endfunction

    function automatic logic o_done(input bit wide);
        return wide ? done16 : done8;
    endfunction

    function automatic logic o_dz(input bit wide);
        return wide ? dz16 : dz8;
    endfunction

    function automatic logic [15:0] o_q(input bit wide);
        return wide ? q16 : {8'd0, q8};
    endfunction

    function automatic logic [15:0] o_r(input bit wide);
        return wide ? r16 : {8'd0, r8};
    endfunction

    task automatic drive(input bit wide, input logic st, input logic [15:0] a, input logic [15:0] b);
        if (wide) begin
            start16 = st;
            dvd16   = a;
            dvs16   = b;
        end else begin
            start8  = st;
            dvd8    = a[7:0];
            dvs8    = b[7:0];
        end
    endtask

    // One division: start in the current cycle (cycle 0), follow it to done,
    // check latency and result, then step into the first IDLE cycle.
    // poke > 0 raises start with 9/3 in that cycle of the run.
    task automatic do_div(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input int poke, input string tag);
        logic [15:0] mask;
        logic [15:0] exp_q, exp_r;
        bit          exp_dz;
        int          width, exp_lat, cyc;

        width   = wide ? 16 : 8;
        mask    = wide ? 16'hFFFF : 16'h00FF;
        a       = a & mask;
        b       = b & mask;
        exp_dz  = (b == 0);
        exp_q   = exp_dz ? mask : a / b;
        exp_r   = exp_dz ? a : a % b;
        exp_lat = exp_dz ? 1 : width + 1;

        chk({tag, " ready_at_start"}, o_ready(wide), 1);
        drive(wide, 1'b1, a, b);
        step();
        // Scramble the operand inputs to show they were latched.
        drive(wide, 1'b0, ~a, ~b);
        cyc = 1;
        while (!o_done(wide) && cyc < 40) begin
            chk({tag, " ready_busy"}, o_ready(wide), 0);
            if (cyc == poke) drive(wide, 1'b1, 16'd9, 16'd3);
            else             drive(wide, 1'b0, ~a, ~b);
            step();
            cyc++;
        end
        drive(wide, 1'b0, 16'd0, 16'd0);
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " quotient"}, o_q(wide), exp_q);
        chk({tag, " remainder"}, o_r(wide), exp_r);
        chk({tag, " div_by_zero"}, o_dz(wide), exp_dz);
        step();
        chk({tag, " done_pulse"}, o_done(wide), 0);
        chk({tag, " ready_after"}, o_ready(wide), 1);
        chk({tag, " quotient_held"}, o_q(wide), exp_q);
        chk({tag, " remainder_held"}, o_r(wide), exp_r);
    endtask

    task automatic quiet(input bit wide, input int cycles, input string tag);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (o_done(wide)) seen++;
            step();
        end
        chk({tag, " no_done"}, seen, 0);
    endtask

    task automatic chk_reset_state(input bit wide, input string tag);
        chk({tag, " quotient"}, o_q(wide), 0);
        chk({tag, " remainder"}, o_r(wide), 0);
        chk({tag, " done"}, o_done(wide), 0);
        chk({tag, " div_by_zero"}, o_dz(wide), 0);
        chk({tag, " ready"}, o_ready(wide), 1);
    endtask

    initial begin
        logic [15:0] ra, rb;

        reset = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        step();
        // Start during reset must be ignored.
        drive(1'b0, 1'b1, 16'd100, 16'd7);
        step();
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        chk_reset_state(1'b0, "rst8");
        chk_reset_state(1'b1, "rst16");
        reset = 1'b0;
        step();
        chk_reset_state(1'b0, "rst8_released");

        // Directed n=8 cases
        do_div(1'b0, 16'd100, 16'd7,  0, "100/7");
        do_div(1'b0, 16'd255, 16'd1,  0, "255/1");
        do_div(1'b0, 16'd5,   16'd9,  0, "5/9");
        do_div(1'b0, 16'd0,   16'd3,  0, "0/3");
        do_div(1'b0, 16'd42,  16'd0,  0, "42/0");
        do_div(1'b0, 16'd10,  16'd3,  0, "10/3");
        do_div(1'b0, 16'd255, 16'd255, 0, "255/255");

        // Start while busy is ignored, and no second done follows.
        do_div(1'b0, 16'd200, 16'd10, 4, "busy_200/10");
        quiet(1'b0, 12, "busy");

        // Reset in cycle 5 of a run abandons it.
        drive(1'b0, 1'b1, 16'd123, 16'd4);
        step();
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state(1'b0, "midrun_rst");
        quiet(1'b0, 15, "midrun_rst");
        do_div(1'b0, 16'd50, 16'd7, 0, "50/7");

        // Random n=8
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = ($urandom_range(0, 6) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
            do_div(1'b0, ra, rb, 0, "rand8");
        end

        // n=16, including back-to-back issue
        do_div(1'b1, 16'd65535, 16'd255, 0, "65535/255");
        do_div(1'b1, 16'd1000,  16'd33,  0, "1000/33");
        do_div(1'b1, 16'd7,     16'd0,   0, "16_7/0");
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            do_div(1'b1, ra, rb, 0, "rand16");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
